// File: rtl/monitor_timer_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// monitor_pkg
//   Shared definitions for the transient monitor with one shared timer.
//   Contents:
//     ch_state_e   per-channel state encoding (2'd3 is illegal, decoded as idle)
//     DEFAULT_UNIT timer cycles per compare step (1 s at 10 kHz)
//     DEFAULT_CW   counter width able to hold DEFAULT_UNIT*16
//     CMP_W        width of the delay-select input
//     idxWidth()   index width for an n-entry vector (never below 1 bit)
// ---------------------------------------------------------------------------
package monitor_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_PENDING = 2'd1,
    CH_OWNER   = 2'd2
  } ch_state_e;

  localparam int DEFAULT_UNIT = 10000;
  localparam int DEFAULT_CW   = 18;
  localparam int CMP_W        = 4;

  // A single-channel build still needs a 1-bit owner/pointer field.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/monitor_timer_scheduler_if.sv
// ---------------------------------------------------------------------------
// monitor_timer_scheduler_if
//   Bundles the monitored inputs, delay select and per-channel results.
//   Signals:
//     i_signal   [NCH]  monitored inputs, one bit per channel
//     i_polarity [NCH]  valid level per channel (1 = valid when high)
//     i_compare  [4]    delay select, load = UNIT*(i_compare+1)
//     o_valid    [NCH]  per-channel valid
//     o_busy            shared timer is owned by a channel
//     o_owner    [OW]   index of the current (or last) owner
//   Modports: master drives inputs / reads results, slave is the monitor.
// ---------------------------------------------------------------------------
interface monitor_timer_scheduler_if #(
  parameter int NCH = 4
);
  import monitor_pkg::*;

  localparam int OW = idxWidth(NCH);

  logic [NCH-1:0]   i_signal;
  logic [NCH-1:0]   i_polarity;
  logic [CMP_W-1:0] i_compare;
  logic [NCH-1:0]   o_valid;
  logic             o_busy;
  logic [OW-1:0]    o_owner;

  modport master (
    output i_signal, i_polarity, i_compare,
    input  o_valid, o_busy, o_owner
  );

  modport slave (
    input  i_signal, i_polarity, i_compare,
    output o_valid, o_busy, o_owner
  );

endinterface

// File: rtl/monitor_timer_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: returns the first requesting index at or
//   after the pointer, searching upward and wrapping.
//   Ports:
//     i_req     [NCH]  request vector
//     i_ptr     [OW]   search start index (kept < NCH by the parent)
//     o_grant   [OW]   chosen index (equals i_ptr when nothing requests)
//     o_anyReq         at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter
  import monitor_pkg::*;
#(
  parameter int NCH = 4,
  parameter int OW  = idxWidth(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [OW-1:0]  i_ptr,
  output logic [OW-1:0]  o_grant,
  output logic           o_anyReq
);

  logic w_found;
  int   w_idx;

  // Walk the channels starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = i_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      w_idx = (int'(i_ptr) + i) % NCH;
      if (!w_found && i_req[w_idx]) begin
        o_grant = OW'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  assign o_anyReq = |i_req;

endmodule

// File: rtl/monitor_timer_scheduler.sv
// ---------------------------------------------------------------------------
// monitor_timer_scheduler
//   Multi-channel transient monitor sharing one down-counter among NCH
//   channels. A channel that goes invalid queues for the timer, is granted it
//   round-robin, and becomes valid again only after a full timer run that
//   ends with its input valid.
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset
//     bus      monitor_timer_scheduler_if.slave (signals, polarity, compare,
//              valid, busy, owner)
//   Parameters: NCH channels, UNIT cycles per compare step, CW counter width
//   (UNIT*16 must fit in CW bits).
// ---------------------------------------------------------------------------
module monitor_timer_scheduler
  import monitor_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int UNIT = DEFAULT_UNIT,
  parameter int CW   = DEFAULT_CW
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  monitor_timer_scheduler_if.slave       bus
);

  localparam int OW = idxWidth(NCH);

  ch_state_e      r_state [NCH];
  logic [CW-1:0]  r_count;
  logic [OW-1:0]  r_rr;
  logic [OW-1:0]  r_owner;
  logic           r_busy;

  logic [NCH-1:0] w_invalid;
  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_valid;
  logic [OW-1:0]  w_grant;
  logic           w_anyReq;
  logic           w_grantFire;
  logic [CW-1:0]  w_load;
  logic [OW-1:0]  w_rrNext;

  assign w_invalid = bus.i_signal ^ bus.i_polarity;

  // Illegal encoding 2'd3 is neither pending nor owner, so it reads as idle.
  always_comb begin
    w_req   = '0;
    w_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      w_req[k]   = (r_state[k] == CH_PENDING);
      w_valid[k] = !((r_state[k] == CH_PENDING) || (r_state[k] == CH_OWNER));
    end
  end

  rr_arbiter #(
    .NCH (NCH),
    .OW  (OW)
  ) u_arbiter (
    .i_req    (w_req),
    .i_ptr    (r_rr),
    .o_grant  (w_grant),
    .o_anyReq (w_anyReq)
  );

  // Grants only while the timer is free, so a release and a new grant can
  // never share an edge: there is always one free cycle between owners.
  assign w_grantFire = !r_busy && w_anyReq;
  assign w_load      = CW'(UNIT) * (CW'(bus.i_compare) + CW'(1));
  assign w_rrNext    = (w_grant == OW'(NCH - 1)) ? '0 : (w_grant + 1'b1);

  // Per-channel state machines plus the shared timer and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_state[k] <= CH_IDLE;
      end
      r_count <= '0;
      r_rr    <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        case (r_state[k])
          CH_PENDING: begin
            if (w_grantFire && (w_grant == OW'(k))) begin
              r_state[k] <= CH_OWNER;
            end
          end
          CH_OWNER: begin
            // A still-invalid input at expiry re-queues behind other channels.
            if (r_count == '0) begin
              r_state[k] <= w_invalid[k] ? CH_PENDING : CH_IDLE;
            end
          end
          default: begin
            r_state[k] <= w_invalid[k] ? CH_PENDING : CH_IDLE;
          end
        endcase
      end

      if (r_busy) begin
        if (r_count != '0) begin
          r_count <= r_count - 1'b1;
        end else begin
          r_busy <= 1'b0;
        end
      end else if (w_anyReq) begin
        r_count <= w_load;
        r_owner <= w_grant;
        r_rr    <= w_rrNext;
        r_busy  <= 1'b1;
      end
    end
  end

  assign bus.o_valid = w_valid;
  assign bus.o_busy  = r_busy;
  assign bus.o_owner = r_owner;

endmodule

// File: tb/tb_monitor_timer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_monitor_timer_scheduler
//   Directed bench for monitor_timer_scheduler with NCH=4, UNIT=4, CW=8.
//   Inputs change on the falling edge; outputs are compared on the falling
//   edge after the rising edge that samples them.
// ---------------------------------------------------------------------------
module tb_monitor_timer_scheduler;
  import monitor_pkg::*;

  localparam int NCH  = 4;
  localparam int UNIT = 4;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rstN;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  monitor_timer_scheduler_if #(.NCH(NCH)) bus ();

  monitor_timer_scheduler #(
    .NCH  (NCH),
    .UNIT (UNIT),
    .CW   (CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  typedef struct {
    logic       rstN;
    logic [3:0] sig;
    logic [3:0] cmp;
    logic [3:0] expValid;
    logic       expBusy;
    logic [1:0] expOwner;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic rst, input logic [3:0] sig,
                                 input logic [3:0] expValid, input logic expBusy,
                                 input logic [1:0] expOwner, input string name);
    vec_t v;
    v.rstN     = rst;
    v.sig      = sig;
    v.cmp      = 4'd1;
    v.expValid = expValid;
    v.expBusy  = expBusy;
    v.expOwner = expOwner;
    v.name     = name;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, let the rising edge sample them, return on the
  // following falling edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] sig, input logic [3:0] cmp);
    rstN          = rst;
    bus.i_signal  = sig;
    bus.i_compare = cmp;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expValid,
                             input logic expBusy, input logic [1:0] expOwner);
    checks++;
    if (bus.o_valid !== expValid || bus.o_busy !== expBusy || bus.o_owner !== expOwner) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%b busy=%b owner=%0d, expected valid=%b busy=%b owner=%0d",
               name, bus.o_valid, bus.o_busy, bus.o_owner, expValid, expBusy, expOwner);
    end
  endtask

  // Glitch ch0 with a given compare and count the busy cycles: L+1 expected.
  task automatic measureLoad(input logic [3:0] cmp, input int expL, input string name);
    int n;
    applyStimulus(1'b0, 4'b1111, cmp);
    applyStimulus(1'b1, 4'b1110, cmp);
    applyStimulus(1'b1, 4'b1111, cmp);
    n = 0;
    while (bus.o_busy === 1'b1 && n < 200) begin
      n++;
      applyStimulus(1'b1, 4'b1111, cmp);
    end
    checks++;
    if (n != expL + 1) begin
      errors++;
      $display("[TB] FAIL %s: got %0d busy cycles, expected %0d", name, n, expL + 1);
    end
    checkOutput({name, "Done"}, 4'b1111, 1'b0, 2'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Table: lone ch0 glitch, then ch0+ch2 together from a fresh reset.
    addVec(1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0, "tblReset");
    addVec(1'b1, 4'b1111, 4'b1111, 1'b0, 2'd0, "tblIdle");
    addVec(1'b1, 4'b1110, 4'b1110, 1'b0, 2'd0, "glitchPend");
    for (int i = 0; i < 9; i++) addVec(1'b1, 4'b1111, 4'b1110, 1'b1, 2'd0, "glitchOwn");
    addVec(1'b1, 4'b1111, 4'b1111, 1'b0, 2'd0, "glitchDone");
    addVec(1'b1, 4'b1111, 4'b1111, 1'b0, 2'd0, "glitchIdle");
    addVec(1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0, "tblReset2");
    addVec(1'b1, 4'b1111, 4'b1111, 1'b0, 2'd0, "tblIdle2");
    addVec(1'b1, 4'b1010, 4'b1010, 1'b0, 2'd0, "dualPend");
    for (int i = 0; i < 9; i++) addVec(1'b1, 4'b1111, 4'b1010, 1'b1, 2'd0, "dualOwn0");
    addVec(1'b1, 4'b1111, 4'b1011, 1'b0, 2'd0, "dualGap");
    for (int i = 0; i < 9; i++) addVec(1'b1, 4'b1111, 4'b1011, 1'b1, 2'd2, "dualOwn2");
    addVec(1'b1, 4'b1111, 4'b1111, 1'b0, 2'd2, "dualDone");

    // Reset held with all inputs invalid, checked before any clock edge.
    rstN           = 1'b1;
    bus.i_polarity = 4'b1111;
    bus.i_signal   = 4'b1111;
    bus.i_compare  = 4'd1;
    #1;
    rstN         = 1'b0;
    bus.i_signal = 4'b0000;
    #1;
    checkOutput("resetAsync", 4'b1111, 1'b0, 2'd0);
    @(negedge clk);
    checkOutput("resetHeld", 4'b1111, 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b0000, 4'd1);
    checkOutput("releasePend", 4'b0000, 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("releaseGrant0", 4'b0000, 1'b1, 2'd0);

    $display("[TB] table vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].sig, vecs[i].cmp);
      checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expBusy, vecs[i].expOwner);
    end

    // ch1 held low for 20 cycles: first expiry re-queues, second one releases.
    applyStimulus(1'b0, 4'b1111, 4'd1);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 4'b1101, 4'd1);
      if (c == 9)       checkOutput("holdFirstZero", 4'b1101, 1'b1, 2'd1);
      else if (c == 10) checkOutput("holdGap", 4'b1101, 1'b0, 2'd1);
      else if (c == 11) checkOutput("holdRegrant", 4'b1101, 1'b1, 2'd1);
      else if (c == 19) checkOutput("holdSecondZero", 4'b1101, 1'b1, 2'd1);
    end
    applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("holdDone", 4'b1111, 1'b0, 2'd1);

    // Round-robin wrap: ch3 runs, then ch0 and ch3 pending together.
    applyStimulus(1'b0, 4'b1111, 4'd1);
    applyStimulus(1'b1, 4'b0111, 4'd1);
    checkOutput("rrPend3", 4'b0111, 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("rrOwn3", 4'b0111, 1'b1, 2'd3);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("rrDone3", 4'b1111, 1'b0, 2'd3);
    applyStimulus(1'b1, 4'b0110, 4'd1);
    checkOutput("rrOwnerHold", 4'b0110, 1'b0, 2'd3);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("rrWrap", 4'b0110, 1'b1, 2'd0);

    // Compare changed mid-count must not stretch the run.
    applyStimulus(1'b0, 4'b1111, 4'd1);
    applyStimulus(1'b1, 4'b1110, 4'd1);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b1111, 4'd15);
    checkOutput("cmpChangeZero", 4'b1110, 1'b1, 2'd0);
    applyStimulus(1'b1, 4'b1111, 4'd15);
    checkOutput("cmpChangeDone", 4'b1111, 1'b0, 2'd0);

    // Load boundaries: smallest and largest delay select.
    measureLoad(4'd0, 4, "load0");
    measureLoad(4'd15, 64, "load15");

    // Low-active polarity: ch3 is valid when low.
    bus.i_polarity = 4'b0111;
    applyStimulus(1'b0, 4'b0111, 4'd1);
    applyStimulus(1'b1, 4'b0111, 4'd1);
    checkOutput("polLowValid", 4'b1111, 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("polLowInvalid", 4'b0111, 1'b0, 2'd0);
    bus.i_polarity = 4'b1111;

    // Reset mid-count, off the clock edge, then a fresh start.
    applyStimulus(1'b0, 4'b1111, 4'd1);
    applyStimulus(1'b1, 4'b1110, 4'd1);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("midCountBusy", 4'b1110, 1'b1, 2'd0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midCountReset", 4'b1111, 1'b0, 2'd0);
    @(negedge clk);
    applyStimulus(1'b1, 4'b1100, 4'd1);
    checkOutput("freshPend", 4'b1100, 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b1111, 4'd1);
    checkOutput("freshGrant", 4'b1100, 1'b1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
